// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register for the RV32 five-stage core.
// Issues req/ack fetches, honours decode stall/flush, and inserts NOP bubbles.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN} state_t;

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] req_addr_reg, req_addr_next;
  logic [31:0] buf_data_reg, buf_data_next;
  logic [31:0] buf_addr_reg, buf_addr_next;
  logic [31:0] if_pc_reg, if_pc_next;
  logic [31:0] if_instr_reg, if_instr_next;
  logic        if_valid_reg, if_valid_next;

  logic [31:0] target;
  logic [31:0] req_inc;
  logic [31:0] drain_pc;
  logic        load_en;
  logic [31:0] load_pc;
  logic [31:0] load_instr;

  assign target  = branch_target_i & 32'hFFFF_FFFC;
  assign req_inc = req_addr_reg + 32'd4;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    req_addr_next = req_addr_reg;
    buf_data_next = buf_data_reg;
    buf_addr_next = buf_addr_reg;
    imem_req_o    = 1'b0;
    imem_addr_o   = 32'h0;
    load_en       = 1'b0;
    load_pc       = buf_addr_reg;
    load_instr    = buf_data_reg;
    drain_pc      = flush_i ? target : pc_reg;

    case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          state_next    = S_FETCH;
          req_addr_next = pc_reg;
        end
      end
      S_FETCH: begin
        imem_req_o  = 1'b1;
        imem_addr_o = req_addr_reg;
        if (imem_ack_i) begin
          if (flush_i) begin
            pc_next       = target;
            req_addr_next = target;
          end else if (stall_i) begin
            buf_data_next = imem_data_i;
            buf_addr_next = req_addr_reg;
            pc_next       = req_inc;
            state_next    = S_HOLD;
          end else begin
            load_en       = 1'b1;
            load_pc       = req_addr_reg;
            load_instr    = imem_data_i;
            pc_next       = req_inc;
            req_addr_next = req_inc;
          end
        end else if (flush_i) begin
          // The request already on the bus must complete before redirecting.
          pc_next    = target;
          state_next = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (flush_i) begin
          pc_next       = target;
          req_addr_next = target;
          buf_data_next = 32'h0;
          buf_addr_next = 32'h0;
          state_next    = S_FETCH;
        end else if (!stall_i) begin
          load_en       = 1'b1;
          req_addr_next = pc_reg;
          state_next    = S_FETCH;
        end
      end
      S_DRAIN: begin
        imem_req_o  = 1'b1;
        imem_addr_o = req_addr_reg;
        pc_next     = drain_pc;
        if (imem_ack_i) begin
          req_addr_next = drain_pc;
          state_next    = S_FETCH;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    if_pc_next    = if_pc_reg;
    if_instr_next = if_instr_reg;
    if_valid_next = if_valid_reg;
    if (flush_i) begin
      if_instr_next = NOP_INSTR;
      if_valid_next = 1'b0;
    end else if (!stall_i) begin
      if (load_en) begin
        if_pc_next    = load_pc;
        if_instr_next = load_instr;
        if_valid_next = 1'b1;
      end else begin
        if_instr_next = NOP_INSTR;
        if_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg    <= S_IDLE;
      pc_reg       <= RESET_PC_AL;
      req_addr_reg <= RESET_PC_AL;
      buf_data_reg <= 32'h0;
      buf_addr_reg <= 32'h0;
      if_pc_reg    <= 32'h0;
      if_instr_reg <= NOP_INSTR;
      if_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      req_addr_reg <= req_addr_next;
      buf_data_reg <= buf_data_next;
      buf_addr_reg <= buf_addr_next;
      if_pc_reg    <= if_pc_next;
      if_instr_reg <= if_instr_next;
      if_valid_reg <= if_valid_next;
    end
  end

  assign pc_o    = if_pc_reg;
  assign instr_o = if_instr_reg;
  assign valid_o = if_valid_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a
// transaction-level model (outstanding request, discard flag, skid queue).
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, stall, flush, ack;
  logic [31:0] tgt;
  logic        imem_req, w_req, valid, w_valid;
  logic [31:0] imem_addr, w_addr, imem_data, w_data;
  logic [31:0] pc_out, w_pc, instr, w_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h100 + a;
  endfunction

  assign imem_data = mem_word(imem_addr);
  assign w_data    = mem_word(w_addr);

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall), .flush_i(flush),
    .branch_target_i(tgt), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(ack), .imem_data_i(imem_data), .pc_o(pc_out), .instr_o(instr),
    .valid_o(valid)
  );

  fetch_unit #(.RESET_PC(WRAP_PC), .NOP_INSTR(NOP)) u_wrap (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall), .flush_i(flush),
    .branch_target_i(tgt), .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_ack_i(ack), .imem_data_i(w_data), .pc_o(w_pc), .instr_o(w_instr),
    .valid_o(w_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: fetch progress described as an outstanding request,
  // whether its reply is to be thrown away, and a queue of parked replies.
  bit          m_started, m_out_valid, m_discard, m_if_valid;
  logic [31:0] m_out_addr, m_next_pc, m_if_pc, m_if_instr;
  logic [31:0] m_skid[$];

  task automatic model_edge();
    logic [31:0] t;
    logic [31:0] skid_a;
    bit acked, got, have_skid;
    if (!rst_n) begin
      m_started = 0; m_out_valid = 0; m_discard = 0;
      m_out_addr = 32'h0; m_next_pc = RST_PC; m_skid.delete();
      m_if_pc = 32'h0; m_if_instr = NOP; m_if_valid = 0;
      return;
    end
    t = tgt & 32'hFFFF_FFFC;
    acked = m_out_valid && ack;
    got = acked && !m_discard;
    have_skid = m_skid.size() > 0;
    skid_a = have_skid ? m_skid[0] : 32'h0;

    if (flush) begin
      m_if_valid = 0; m_if_instr = NOP;
    end else if (!stall) begin
      if (have_skid) begin
        m_if_pc = skid_a; m_if_instr = mem_word(skid_a); m_if_valid = 1;
      end else if (got) begin
        m_if_pc = m_out_addr; m_if_instr = mem_word(m_out_addr); m_if_valid = 1;
      end else begin
        m_if_valid = 0; m_if_instr = NOP;
      end
    end

    if (!m_started) begin
      if (start) begin
        m_started = 1; m_out_valid = 1; m_out_addr = m_next_pc; m_discard = 0;
      end
    end else if (flush) begin
      m_skid.delete();
      m_next_pc = t;
      if (m_out_valid && !acked) m_discard = 1;
      else begin
        m_out_valid = 1; m_out_addr = t; m_discard = 0;
      end
    end else if (acked && m_discard) begin
      m_out_addr = m_next_pc; m_discard = 0;
    end else if (got && stall) begin
      m_skid.push_back(m_out_addr);
      m_out_valid = 0;
      m_next_pc = m_out_addr + 32'd4;
    end else if (got) begin
      m_out_addr = m_out_addr + 32'd4;
      m_next_pc = m_out_addr;
    end else if (have_skid && !stall) begin
      m_skid.delete();
      m_out_valid = 1; m_out_addr = m_next_pc;
    end
  endtask

  task automatic compare_model();
    check("req",   {31'b0, imem_req}, {31'b0, m_out_valid});
    check("addr",  imem_addr, m_out_valid ? m_out_addr : 32'h0);
    check("valid", {31'b0, valid}, {31'b0, m_if_valid});
    check("pc",    pc_out, m_if_pc);
    check("instr", instr, m_if_instr);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0; ack = 1'b0; tgt = 32'h0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0; ack = 1'b0; tgt = 32'h0;
    @(negedge clk);
    step();
    step();
    check("rst_req",   {31'b0, imem_req}, 32'd0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_pc",    pc_out, 32'h0);
    check("rst_instr", instr, NOP);
    check("rst_valid", {31'b0, valid}, 32'd0);

    // Streaming from both reset addresses, including the 32-bit wrap.
    rst_n = 1'b1; start = 1'b1; ack = 1'b1;
    step();
    start = 1'b0;
    check("start_req",  {31'b0, imem_req}, 32'd1);
    check("start_addr", imem_addr, RST_PC);
    check("wrap_addr0", w_addr, WRAP_PC);
    for (int k = 0; k < 6; k++) begin
      step();
      check("stream_pc",    pc_out, 32'(4 * k));
      check("stream_instr", instr, 32'h100 + 32'(4 * k));
      check("stream_valid", {31'b0, valid}, 32'd1);
      if (k < 3) begin
        check("wrap_addr", w_addr, 32'hFFFF_FFFC + 32'(4 * k));
        check("wrap_pc",   w_pc,   WRAP_PC + 32'(4 * k));
      end
    end

    // Wait states: reply on every third cycle.
    for (int r = 0; r < 4; r++) begin
      ack = 1'b0;
      step();
      check("wait_valid", {31'b0, valid}, 32'd0);
      check("wait_nop",   instr, NOP);
      step();
      ack = 1'b1;
      step();
      check("wait_deliver", {31'b0, valid}, 32'd1);
    end

    // Stall with a reply arriving in the first stalled cycle.
    do_reset();
    start = 1'b1; ack = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    stall = 1'b1;
    step();
    check("hold_pc",  pc_out, 32'h4);
    check("hold_req", {31'b0, imem_req}, 32'd0);
    ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_pc",  pc_out, 32'h4);
      check("hold_req", {31'b0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    check("unstall_pc",    pc_out, 32'h8);
    check("unstall_valid", {31'b0, valid}, 32'd1);
    check("unstall_addr",  imem_addr, 32'hC);

    // Flush while a request is outstanding.
    do_reset();
    start = 1'b1; ack = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    ack = 1'b0; flush = 1'b1; tgt = 32'h203;
    step();
    check("flush_valid", {31'b0, valid}, 32'd0);
    check("drain_addr",  imem_addr, 32'h10);
    flush = 1'b0;
    step();
    check("drain_addr2", imem_addr, 32'h10);
    ack = 1'b1;
    step();
    check("redirect_addr",  imem_addr, 32'h200);
    check("drop_valid",     {31'b0, valid}, 32'd0);
    step();
    check("target_pc",    pc_out, 32'h200);
    check("target_instr", instr, 32'h300);

    // Flush, stall and reply together: flush wins.
    flush = 1'b1; stall = 1'b1; tgt = 32'h400;
    step();
    check("fsa_valid", {31'b0, valid}, 32'd0);
    check("fsa_addr",  imem_addr, 32'h400);
    flush = 1'b0; stall = 1'b0;
    step();
    check("fsa_pc", pc_out, 32'h400);

    // Reset during a wait with a concurrent reply.
    ack = 1'b0;
    step();
    rst_n = 1'b0; ack = 1'b1;
    step();
    check("rstmid_req",   {31'b0, imem_req}, 32'd0);
    check("rstmid_valid", {31'b0, valid}, 32'd0);
    check("rstmid_instr", instr, NOP);
    rst_n = 1'b1; ack = 1'b0;
    step();
    check("rstmid_idle", {31'b0, imem_req}, 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom % 64) != 0;
      start = ($urandom % 4) == 0;
      stall = ($urandom % 4) == 0;
      flush = ($urandom % 8) == 0;
      ack   = ($urandom % 2) == 0;
      tgt   = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage plus IF/ID pipeline register for the five-stage RV32 core. Holds the PC, issues requests to instruction memory over a req/ack handshake, and presents the fetched instruction and its PC to the decode stage. The immediate generator and the register file consume `instr_o`. Honours load-use stalls and branch flushes from decode, and inserts a canonical NOP bubble whenever no valid instruction is available.

## Interface
- `RESET_PC`, default 32'h0000_0000, first fetch address after start.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`), bubble encoding driven on `instr_o`.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-low.
- `start_i`  in  1  begins fetching; sampled only in IDLE.
- `stall_i`  in  1  decode stall; IF/ID must hold its contents.
- `flush_i`  in  1  branch taken in decode; kill the younger instruction and redirect.
- `branch_target_i`  in  32  redirect address, valid while `flush_i`=1.
- `imem_req_o`  out  1  instruction memory request.
- `imem_addr_o`  out  32  request address; bits [1:0] are always 0.
- `imem_ack_i`  in  1  memory returns `imem_data_i` this cycle.
- `imem_data_i`  in  32  fetched instruction word.
- `pc_o`  out  32  IF/ID PC.
- `instr_o`  out  32  IF/ID instruction.
- `valid_o`  out  1  IF/ID holds a real instruction.

## Operation
- Registers:
  - `pc`: next address to request.
  - `req_addr`: address of the outstanding request.
  - 32-bit skid buffer `buf` with its address.
  - FSM state.
  - IF/ID register (`pc_o`, `instr_o`, `valid_o`).
- Reset (`rst_i`=0 at an edge): state=IDLE, `pc`=`RESET_PC`, `imem_req_o`=0, `imem_addr_o`=0, `pc_o`=0, `instr_o`=`NOP_INSTR`, `valid_o`=0. Buffer is cleared. Any outstanding ack is forgotten.
- Flush has priority over stall everywhere.
- IF/ID update rules, in priority order:
  - `flush_i` → bubble (`valid_o`=0, `instr_o`=NOP, `pc_o` unchanged).
  - else `stall_i` → hold.
  - else load from the state-dependent source below.
  - else bubble.
- **IDLE**:
  - `imem_req_o`=0.
  - `start_i`=1 → FETCH, with `req_addr`=`pc`.
- **FETCH**:
  - `imem_req_o`=1, `imem_addr_o`=`req_addr`.
  - ack & flush: discard data; `pc`, `req_addr` ← `{branch_target_i[31:2],2'b00}`; stay in FETCH.
  - ack & stall: `buf` ← data; `pc` ← `req_addr`+4; → HOLD.
  - ack only: IF/ID ← (`req_addr`, data, 1); `req_addr`, `pc` ← `req_addr`+4; stay in FETCH.
  - no ack & flush: `pc` ← target; → DRAIN. The outstanding request keeps its address.
  - no ack: `req_addr` stable; IF/ID bubble unless stalled.
- **HOLD**:
  - `imem_req_o`=0.
  - flush: drop `buf`; `pc`, `req_addr` ← target; → FETCH.
  - `stall_i`=0: IF/ID ← `buf`; `req_addr` ← `pc`; → FETCH.
- **DRAIN**:
  - `imem_req_o`=1 with the old `req_addr`.
  - A further flush overwrites `pc` with the new target.
  - ack: discard data; `req_addr` ← `pc`; → FETCH.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- `branch_target_i[1:0]` is ignored (forced to 0).
- `start_i` is ignored outside IDLE. Only reset returns the block to IDLE.

## Timing
- Handshake:
  - Once `imem_req_o` rises, `imem_addr_o` is stable until the cycle of `imem_ack_i`, inclusive.
  - `imem_ack_i` while `imem_req_o`=0 is ignored.
- Latency:
  - Ack in the same cycle as req (zero-wait memory) is legal.
  - Ack at edge N → `valid_o`/`instr_o` updated after edge N.
- Throughput: 1 instruction/cycle with ack held high and no stall.
- Start: the `start_i` edge in IDLE → `imem_req_o`=1 from the next cycle, address `RESET_PC`.
- Flush:
  - `valid_o`=0 in the cycle after the `flush_i` edge.
  - The first target instruction appears 1 cycle after its ack.
- Stall: IF/ID outputs hold bit-exact for every cycle `stall_i`=1 without flush.
- Reset mid-transfer: the next state is IDLE irrespective of `imem_ack_i`.

## Test plan
- **Streaming**:
  - Stimulus: reset, `start_i` pulse, ack always 1, data = 0x100+addr.
  - Required: `pc_o` = 0, 4, 8, … on consecutive cycles; `valid_o`=1 from the 2nd cycle after start.
- **Wait states**:
  - Stimulus: ack after 3 cycles per request.
  - Required: `imem_addr_o` constant for 3 cycles; `valid_o` pulses once per 3 cycles; bubbles carry `instr_o`=0x00000013.
- **Stall with ack**:
  - Stimulus: `stall_i`=1 for 4 cycles, ack arrives in the 1st stalled cycle for addr 0x8.
  - Required: IF/ID holds addr 0x4; `imem_req_o`=0 during HOLD; addr 0x8 emerges one cycle after stall drops; no instruction lost or duplicated.
- **Flush during outstanding request**:
  - Stimulus: req to 0x10 pending, `flush_i`=1 with target 0x203, ack 2 cycles later.
  - Required: data for 0x10 dropped; the next request address is 0x200; `valid_o`=0 the cycle after the flush.
- **Flush+stall+ack same cycle**:
  - Required: flush wins; data discarded; `valid_o`=0; `req_addr`=target.
- **Wrap and reset**:
  - Stimulus: `RESET_PC`=0xFFFF_FFF8 streaming.
  - Required: addresses go FFF8, FFFC, 0000.
  - Stimulus: `rst_i`=0 mid-wait with a concurrent ack.
  - Required: IDLE next cycle; `valid_o`=0; `instr_o`=NOP; `imem_req_o`=0.
